// File: rtl/addmul_arb_pkg.sv
// Shared encodings for the add/multiply arbiter: FSM states, op codes, requester ids.
// The optional ADDMUL_ARB_EARLY_EXIT_EN build only affects addmul_seq_mul.
package addmul_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_MUL  = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_ADD  = ST_ADD,
    S_MUL  = ST_MUL,
    S_RESP = ST_RESP
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  // Round-robin pointer moves to whichever requester was not just served.
  function automatic logic other_id(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/addmul_seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, product truncated to 2*p_width+1 bits.
// Define ADDMUL_ARB_EARLY_EXIT_EN to stop as soon as the remaining multiplier bits are all zero.
module addmul_seq_mul #(
  parameter int p_width = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [p_width:0]     a,
  input  logic [p_width:0]     b,
  output logic                 done,
  output logic [2*p_width:0]   product
);

  localparam int RW = 2 * p_width + 1;
  localparam int CW = $clog2(p_width + 2);
  localparam logic [CW-1:0] LAST_ITER = CW'(p_width);

  logic [RW-1:0]    acc_q, acc_d;
  logic [RW-1:0]    mcand_q, mcand_d;
  logic [p_width:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             active_q, active_d;

  // Arithmetic wraps at RW bits, which is exactly the required truncation.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    done     = 1'b0;
    if (start) begin
      acc_d    = '0;
      mcand_d  = RW'(a);
      mplier_d = b;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
`ifdef ADDMUL_ARB_EARLY_EXIT_EN
      done = (cnt_q == LAST_ITER) || (mplier_d == '0);
`else
      done = (cnt_q == LAST_ITER);
`endif
      if (done) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign product = acc_q;

endmodule

// File: rtl/addmul_arbiter.sv
// Round-robin arbiter sharing one add / iterative-multiply datapath between two requesters.
// Optional build macro ADDMUL_ARB_EARLY_EXIT_EN shortens multiplies with small multipliers.
module addmul_arbiter #(
  parameter int p_width = 1
) (
  input  logic               i_w_clk,
  input  logic               i_w_rst_n,
  input  logic               i_w_req0_valid,
  output logic               o_w_req0_ready,
  input  logic [p_width:0]   i_w_req0_a,
  input  logic [p_width:0]   i_w_req0_b,
  input  logic               i_w_req0_sel,
  input  logic               i_w_req1_valid,
  output logic               o_w_req1_ready,
  input  logic [p_width:0]   i_w_req1_a,
  input  logic [p_width:0]   i_w_req1_b,
  input  logic               i_w_req1_sel,
  output logic               o_w_res_valid,
  input  logic               i_w_res_ready,
  output logic [2*p_width:0] o_w_res_data,
  output logic               o_w_res_id,
  output logic               o_w_busy
);

  import addmul_arb_pkg::*;

  localparam int RW = 2 * p_width + 1;

  state_e           state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [p_width:0] a_q, a_d;
  logic [p_width:0] b_q, b_d;
  logic             sel_q, sel_d;
  logic             id_q, id_d;
  logic [RW-1:0]    res_data_q, res_data_d;
  logic             res_valid_q, res_valid_d;

  logic             in_idle;
  logic             gnt0;
  logic             gnt1;
  logic             accept;
  logic             acc_id;
  logic [p_width:0] acc_a;
  logic [p_width:0] acc_b;
  logic             acc_sel;
  logic             mul_start;
  logic             mul_done;
  logic [RW-1:0]    mul_product;
  logic [RW-1:0]    sum;

  // Readies are held low while reset is asserted so nothing can be granted then.
  always_comb begin
    in_idle   = (state_q == S_IDLE) && i_w_rst_n;
    gnt0      = in_idle && i_w_req0_valid && (!i_w_req1_valid || (rr_ptr_q == ID_REQ0));
    gnt1      = in_idle && i_w_req1_valid && (!i_w_req0_valid || (rr_ptr_q == ID_REQ1));
    accept    = gnt0 || gnt1;
    acc_id    = gnt1 ? ID_REQ1 : ID_REQ0;
    acc_a     = gnt1 ? i_w_req1_a : i_w_req0_a;
    acc_b     = gnt1 ? i_w_req1_b : i_w_req0_b;
    acc_sel   = gnt1 ? i_w_req1_sel : i_w_req0_sel;
    mul_start = accept && (acc_sel == OP_MUL);
    sum       = RW'(a_q) + RW'(b_q);
  end

  addmul_seq_mul #(
    .p_width(p_width)
  ) u_mul (
    .clk    (i_w_clk),
    .rst_n  (i_w_rst_n),
    .start  (mul_start),
    .a      (acc_a),
    .b      (acc_b),
    .done   (mul_done),
    .product(mul_product)
  );

  // RESP spends its first cycle loading the result register, then raises valid.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    id_d        = id_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d      = acc_a;
          b_d      = acc_b;
          sel_d    = acc_sel;
          id_d     = acc_id;
          rr_ptr_d = other_id(acc_id);
          state_d  = (acc_sel == OP_MUL) ? S_MUL : S_ADD;
        end
      end
      S_ADD: begin
        res_data_d = sum;
        state_d    = S_RESP;
      end
      S_MUL: begin
        if (mul_done) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (!res_valid_q) begin
          res_valid_d = 1'b1;
          if (sel_q == OP_MUL) begin
            res_data_d = mul_product;
          end
        end else if (i_w_res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= ID_REQ0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= OP_ADD;
      id_q        <= ID_REQ0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      id_q        <= id_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign o_w_req0_ready = gnt0;
  assign o_w_req1_ready = gnt1;
  assign o_w_res_valid  = res_valid_q;
  assign o_w_res_data   = res_data_q;
  assign o_w_res_id     = id_q;
  assign o_w_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_addmul_arbiter.sv
// Self-checking bench for addmul_arbiter (p_width=3) against a behavioural arbitration/arithmetic model.
// Latency expectations follow ADDMUL_ARB_EARLY_EXIT_EN when it is defined.
module tb_addmul_arbiter;

  localparam int P  = 3;
  localparam int W  = P + 1;
  localparam int RW = 2 * P + 1;

  logic          i_w_clk = 1'b0;
  logic          i_w_rst_n = 1'b0;
  logic          i_w_req0_valid = 1'b0;
  logic          o_w_req0_ready;
  logic [W-1:0]  i_w_req0_a = '0;
  logic [W-1:0]  i_w_req0_b = '0;
  logic          i_w_req0_sel = 1'b0;
  logic          i_w_req1_valid = 1'b0;
  logic          o_w_req1_ready;
  logic [W-1:0]  i_w_req1_a = '0;
  logic [W-1:0]  i_w_req1_b = '0;
  logic          i_w_req1_sel = 1'b0;
  logic          o_w_res_valid;
  logic          i_w_res_ready = 1'b0;
  logic [RW-1:0] o_w_res_data;
  logic          o_w_res_id;
  logic          o_w_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int model_rr = 0;
  int grant_cnt[2];

  addmul_arbiter #(.p_width(P)) dut (
    .i_w_clk        (i_w_clk),
    .i_w_rst_n      (i_w_rst_n),
    .i_w_req0_valid (i_w_req0_valid),
    .o_w_req0_ready (o_w_req0_ready),
    .i_w_req0_a     (i_w_req0_a),
    .i_w_req0_b     (i_w_req0_b),
    .i_w_req0_sel   (i_w_req0_sel),
    .i_w_req1_valid (i_w_req1_valid),
    .o_w_req1_ready (o_w_req1_ready),
    .i_w_req1_a     (i_w_req1_a),
    .i_w_req1_b     (i_w_req1_b),
    .i_w_req1_sel   (i_w_req1_sel),
    .o_w_res_valid  (o_w_res_valid),
    .i_w_res_ready  (i_w_res_ready),
    .o_w_res_data   (o_w_res_data),
    .o_w_res_id     (o_w_res_id),
    .o_w_busy       (o_w_busy)
  );

  always #5 i_w_clk = ~i_w_clk;

  task automatic checkOutput(input string tag, input longint unsigned got, input longint unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint unsigned exp_result(input int unsigned a, input int unsigned b, input bit sel);
    longint unsigned r;
    if (sel) r = (longint'(a) * longint'(b)) % (64'd1 << RW);
    else     r = longint'(a) + longint'(b);
    return r;
  endfunction

  // Edges from the accept edge until valid is observed.
  function automatic int exp_latency(input int unsigned b, input bit sel);
    int n;
    if (!sel) return 2;
    n = P + 1;
`ifdef ADDMUL_ARB_EARLY_EXIT_EN
    n = 0;
    for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
    if (n == 0) n = 1;
`endif
    return n + 1;
  endfunction

  task automatic scramble_inputs(input bit v);
    i_w_req0_valid = v;
    i_w_req1_valid = v;
    i_w_req0_a   = W'($urandom);
    i_w_req0_b   = W'($urandom);
    i_w_req0_sel = 1'($urandom);
    i_w_req1_a   = W'($urandom);
    i_w_req1_b   = W'($urandom);
    i_w_req1_sel = 1'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_ready0"}, o_w_req0_ready, 0);
    checkOutput({tag, "_ready1"}, o_w_req1_ready, 0);
    checkOutput({tag, "_valid"},  o_w_res_valid, 0);
    checkOutput({tag, "_data"},   o_w_res_data, 0);
    checkOutput({tag, "_id"},     o_w_res_id, 0);
    checkOutput({tag, "_busy"},   o_w_busy, 0);
  endtask

  // One full transaction: present requests, check grant, wait for result, hold, handshake.
  task automatic applyStimulus(input bit v0, input int unsigned a0, input int unsigned b0, input bit s0,
                               input bit v1, input int unsigned a1, input int unsigned b1, input bit s1,
                               input int hold);
    int gid;
    int unsigned ea, eb;
    bit es;
    longint unsigned exp_data;
    int lat;
    i_w_req0_valid = v0; i_w_req0_a = W'(a0); i_w_req0_b = W'(b0); i_w_req0_sel = s0;
    i_w_req1_valid = v1; i_w_req1_a = W'(a1); i_w_req1_b = W'(b1); i_w_req1_sel = s1;
    #1;
    if (v0 && v1) gid = model_rr;
    else if (v0)  gid = 0;
    else          gid = 1;
    checkOutput("grant_ready0", o_w_req0_ready, (gid == 0));
    checkOutput("grant_ready1", o_w_req1_ready, (gid == 1));
    ea = (gid == 0) ? (a0 % W'(0) + a0 % (1 << W)) : (a1 % (1 << W));
    ea = (gid == 0) ? (a0 % (1 << W)) : ea;
    eb = (gid == 0) ? (b0 % (1 << W)) : (b1 % (1 << W));
    es = (gid == 0) ? s0 : s1;
    exp_data = exp_result(ea, eb, es);
    @(posedge i_w_clk); #1;
    model_rr = 1 - gid;
    grant_cnt[gid]++;
    scramble_inputs(1'b0);
    checkOutput("busy_after_accept", o_w_busy, 1);
    lat = 0;
    do begin
      @(posedge i_w_clk); #1;
      lat++;
    end while (!o_w_res_valid && lat < 40);
    checkOutput("latency", lat, exp_latency(eb, es));
    checkOutput("res_data", o_w_res_data, exp_data);
    checkOutput("res_id", o_w_res_id, gid);
    for (int k = 0; k < hold; k++) begin
      scramble_inputs(1'b1);
      #1;
      checkOutput("hold_ready0", o_w_req0_ready, 0);
      checkOutput("hold_ready1", o_w_req1_ready, 0);
      @(posedge i_w_clk); #1;
      checkOutput("hold_valid", o_w_res_valid, 1);
      checkOutput("hold_data", o_w_res_data, exp_data);
      checkOutput("hold_id", o_w_res_id, gid);
      checkOutput("hold_busy", o_w_busy, 1);
    end
    scramble_inputs(1'b0);
    i_w_res_ready = 1'b1;
    @(posedge i_w_clk); #1;
    i_w_res_ready = 1'b0;
    checkOutput("after_hs_valid", o_w_res_valid, 0);
    checkOutput("after_hs_busy", o_w_busy, 0);
  endtask

  initial begin
    int g0_start;
    int g1_start;
    grant_cnt[0] = 0;
    grant_cnt[1] = 0;
    $display("[TB] start, p_width=%0d", P);

    i_w_req0_valid = 1'b1;
    #12;
    check_all_zero("reset");
    i_w_req0_valid = 1'b0;
    @(posedge i_w_clk); #1;
    i_w_rst_n = 1'b1;
    model_rr = 0;

    // Contention: both valid every time, grants must alternate starting at requester 0.
    g0_start = grant_cnt[0];
    g1_start = grant_cnt[1];
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, $urandom, $urandom, 1'($urandom), 1'b1, $urandom, $urandom, 1'($urandom), 0);
    end
    checkOutput("contention_grants0", grant_cnt[0] - g0_start, 4);
    checkOutput("contention_grants1", grant_cnt[1] - g1_start, 4);

    applyStimulus(1'b1, 3, 3, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 13, 11, 1'b1, 3);
    applyStimulus(1'b1, 15, 15, 1'b1, 1'b0, 0, 0, 1'b0, 10);
    applyStimulus(1'b1, 9, 1, 1'b1, 1'b0, 0, 0, 1'b0, 0);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 9, 0, 1'b1, 0);
    applyStimulus(1'b1, 15, 15, 1'b0, 1'b0, 0, 0, 1'b0, 1);

    for (int i = 0; i < 40; i++) begin
      bit v0, v1;
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      applyStimulus(v0, $urandom, $urandom, 1'($urandom), v1, $urandom, $urandom, 1'($urandom),
                    $urandom_range(0, 3));
    end

    // Leave a nonzero result with id 1, then reset in the middle of a multiply from requester 0.
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 5, 6, 1'b0, 0);
    i_w_req0_valid = 1'b1; i_w_req0_a = 4'd15; i_w_req0_b = 4'd15; i_w_req0_sel = 1'b1;
    i_w_req1_valid = 1'b0;
    #1;
    checkOutput("midmul_accept_ready0", o_w_req0_ready, 1);
    @(posedge i_w_clk); #1;
    i_w_req0_valid = 1'b0;
    @(posedge i_w_clk); #1;
    checkOutput("midmul_busy", o_w_busy, 1);
    i_w_rst_n = 1'b0;
    i_w_req0_valid = 1'b1;
    #1;
    check_all_zero("midmul_reset");
    i_w_req0_valid = 1'b0;
    @(posedge i_w_clk); #1;
    check_all_zero("midmul_reset_held");
    i_w_rst_n = 1'b1;
    model_rr = 0;
    applyStimulus(1'b1, 2, 7, 1'b1, 1'b1, 4, 4, 1'b0, 0);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 6, 5, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/addmul_arbiter.md
# addmul_arbiter

Sequential controller that shares one add/multiply datapath between two requesters. Each requester submits an operand pair plus an operation select over a valid/ready handshake. A round-robin arbiter grants one request at a time. Add completes in one execute cycle; multiply runs as an iterative shift-add over p_width+1 cycles. The result is held on a valid/ready response port tagged with the requester id. The block sits between client logic and the arithmetic unit, replacing its purely combinational select.

## Interface
- p_width, 1: operands are p_width+1 bits; result is 2*p_width+1 bits; legal values are ≥1.
- i_w_clk  in  1  clock, rising edge.
- i_w_rst_n  in  1  asynchronous active-low reset.
- i_w_req0_valid  in  1  requester 0 has a request.
- o_w_req0_ready  out  1  requester 0 request accepted this cycle if valid.
- i_w_req0_a, i_w_req0_b  in  p_width+1  requester 0 operands.
- i_w_req0_sel  in  1  0 = add, 1 = multiply.
- i_w_req1_valid, o_w_req1_ready, i_w_req1_a, i_w_req1_b, i_w_req1_sel: same for requester 1.
- o_w_res_valid  out  1  result available.
- i_w_res_ready  in  1  consumer takes the result.
- o_w_res_data  out  2*p_width+1  result.
- o_w_res_id  out  1  requester that issued the result.
- o_w_busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ADD, MUL, RESP.
- IDLE
  - Grant logic:
    - Only one requester valid: that requester is granted.
    - Both valid: requester `rr_ptr` is granted.
  - The granted requester's ready is high. The other ready is low. Both readies are low outside IDLE.
  - On accept (valid && ready): capture a, b, sel and id, then set rr_ptr <= ~id.
  - Next state: ADD if sel=0, MUL if sel=1.
- ADD: result <= zero-extend(a + b) (p_width+2 bits) to 2*p_width+1 bits, then go to RESP.
- MUL
  - Accumulator starts at 0, multiplicand = a, multiplier = b.
  - Each cycle:
    - if multiplier[0], acc += multiplicand;
    - multiplicand <<= 1;
    - multiplier >>= 1;
    - iteration counter increments.
  - Exit to RESP after p_width+1 iterations.
  - Result is the low 2*p_width+1 bits of the product (truncation is required).
- RESP
  - o_w_res_valid=1; data and id are stable.
  - On i_w_res_ready, go to IDLE. A new request can be accepted no earlier than the next cycle.
- Reset (asynchronous, any state, including mid-MUL)
  - state=IDLE, rr_ptr=0.
  - All outputs 0: readies, o_w_res_valid, o_w_res_data, o_w_res_id, o_w_busy.
  - Any in-flight operation is discarded.

## Timing
- Accept at edge N.
- Add: o_w_res_valid high after edge N+2 (ADD cycle, then the result register).
- Multiply: o_w_res_valid high after edge N+p_width+2 (p_width+1 MUL cycles, then RESP).
- Response: throughput is one operation in flight; back-to-back minimum is accept → ... → RESP handshake → IDLE → next accept.
- Readies are combinational from state, rr_ptr and the two valids. Valids must not depend combinationally on readies.
- A requester that drops valid before acceptance loses no state. Operands are only sampled on accept.

## Configuration
- ADDMUL_ARB_EARLY_EXIT_EN
  - Defined: MUL exits to RESP as soon as the remaining multiplier is zero, or after p_width+1 iterations, whichever comes first.
  - b=0 takes one MUL cycle; the result is unchanged.
  - Undefined: MUL always runs exactly p_width+1 cycles, giving fixed latency.

## Structure
- Package addmul_arb_pkg:
  - state encoding localparams (IDLE/ADD/MUL/RESP);
  - op codes OP_ADD=1'b0, OP_MUL=1'b1;
  - requester id constants.
- Sub-module addmul_seq_mul
  - Holds the shift-add iteration registers: acc, multiplicand, multiplier, counter.
  - Interface: start, done, operands, product.
- The top contains the arbiter, FSM and result register.

## Test plan
- Reset while MUL in flight (p_width=3, a=15, b=15, reset asserted in 2nd MUL cycle) → all outputs 0 immediately, IDLE, rr_ptr=0; next request from requester 1 alone is granted.
- Single add, p_width=1: req0 a=3, b=3, sel=0 → o_w_res_data=6, id=0, valid after 2 edges.
- Single multiply, p_width=3: req1 a=13, b=11, sel=1 → data=143 truncated to 7 bits = 15, id=1; valid after 5 edges (no macro); held until i_w_res_ready.
- Contention: both valid every cycle → grants alternate 0,1,0,1 starting from 0 after reset; no starvation over 8 operations.
- Backpressure: i_w_res_ready low for 10 cycles in RESP → data/id stable, both readies 0, o_w_busy=1.
- Early exit (macro defined, p_width=3): a=9, b=1 → result 9 after 1 MUL cycle (valid after edge 3); b=0 → result 0 after 1 MUL cycle.
